sys_array_ctrl: RTL and testbench

Sequencer for the N x N systolic PE array.
- Holds the A (N x K) and B (K x N) operand matrices, loaded by the host.
- On start, clears the PE accumulators, then streams skewed operands into the array's west (A) and north (B) edges.
- Waits for the pipeline to drain, then pulses done.
- Tracks sticky PE errors and the cycle count of each run.
- Sits between the host/test harness and sys_array, replacing the array's free-running self-start.

---
 rtl/dsp_sys_arr_pkg.sv | 19 +
 rtl/sys_array_ctrl_if.sv | 37 +++
 rtl/sys_arr_operand_buf.sv | 56 +++++
 rtl/sys_array_ctrl.sv | 127 ++++++++++++
 tb/tb_sys_array_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_sys_arr_pkg.sv
// Shared types and elaboration helpers for the systolic array sequencer.
package dsp_sys_arr_pkg;

  typedef logic [31:0] single_float;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} ctrl_state_t;

  typedef enum logic {MAT_A, MAT_B} mat_sel_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // One spare code point so that an index equal to the dimension is representable and can be rejected.
  function automatic int idx_w(input int n, input int k);
    return $clog2(((n > k) ? n : k) + 1);
  endfunction

endpackage

// File: rtl/sys_array_ctrl_if.sv
// Host/array-facing bus of the sequencer: operand loads, run control, skewed edge feeds, status.
interface sys_array_ctrl_if #(
  parameter int N = 2,
  parameter int K = 2
);
  import dsp_sys_arr_pkg::*;

  localparam int IDX_W = idx_w(N, K);

  logic                  start;
  logic                  ld_en;
  mat_sel_t              ld_sel;
  logic [IDX_W-1:0]      ld_row;
  logic [IDX_W-1:0]      ld_col;
  single_float           ld_data;
  logic [N*N-1:0]        pe_error;
  single_float [N-1:0]   a_out;
  logic [N-1:0]          a_valid;
  single_float [N-1:0]   b_out;
  logic [N-1:0]          b_valid;
  logic                  pe_clear;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [31:0]           cycle_count;

  modport master (
    output start, ld_en, ld_sel, ld_row, ld_col, ld_data, pe_error,
    input  a_out, a_valid, b_out, b_valid, pe_clear, busy, done, error, cycle_count
  );

  modport slave (
    input  start, ld_en, ld_sel, ld_row, ld_col, ld_data, pe_error,
    output a_out, a_valid, b_out, b_valid, pe_clear, busy, done, error, cycle_count
  );

endinterface

// File: rtl/sys_arr_operand_buf.sv
// R x C operand register file with one write port and one skew read port per lane:
// row-indexed lanes (out[r] = mem[r][sel[r]]) or column-indexed lanes (out[c] = mem[sel[c]][c]).
module sys_arr_operand_buf
  import dsp_sys_arr_pkg::*;
#(
  parameter int  R        = 2,
  parameter int  C        = 2,
  parameter int  IDX_W    = 2,
  parameter bit  COL_READ = 1'b0,
  localparam int LANES    = COL_READ ? C : R,
  localparam int DEPTH    = COL_READ ? R : C,
  localparam int SEL_W    = clog2_min1(DEPTH)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        we,
  input  logic [IDX_W-1:0]            wr_row,
  input  logic [IDX_W-1:0]            wr_col,
  input  single_float                 wr_data,
  input  logic [LANES-1:0][SEL_W-1:0] rd_sel,
  output single_float [LANES-1:0]     rd_data
);

  single_float mem [R][C];

  // Matching every cell against the index drops out-of-range writes without a separate check.
  always_ff @(posedge CLK) begin
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        if (RST)
          mem[r][c] <= '0;
        else if (we && wr_row == IDX_W'(r) && wr_col == IDX_W'(c))
          mem[r][c] <= wr_data;
      end
    end
  end

  if (COL_READ) begin : g_col
    always_comb begin
      for (int l = 0; l < LANES; l++) begin
        rd_data[l] = '0;
        for (int e = 0; e < DEPTH; e++)
          if (rd_sel[l] == SEL_W'(e)) rd_data[l] = mem[e][l];
      end
    end
  end else begin : g_row
    always_comb begin
      for (int l = 0; l < LANES; l++) begin
        rd_data[l] = '0;
        for (int e = 0; e < DEPTH; e++)
          if (rd_sel[l] == SEL_W'(e)) rd_data[l] = mem[l][e];
      end
    end
  end

endmodule

// File: rtl/sys_array_ctrl.sv
// Systolic array sequencer: clears PEs, streams skewed A/B operands, drains, pulses done,
// and tracks sticky PE errors and the run length.
module sys_array_ctrl
  import dsp_sys_arr_pkg::*;
#(
  parameter int N      = 2,
  parameter int K      = 2,
  parameter int PE_LAT = 4
) (
  input  logic               CLK,
  input  logic               RST,
  sys_array_ctrl_if.slave    bus
);

  localparam int FEED_LEN  = K + N - 1;
  localparam int DRAIN_CYC = 2 * (N - 1) + PE_LAT;
  localparam int CNT_W     = clog2_min1((FEED_LEN > DRAIN_CYC) ? FEED_LEN : DRAIN_CYC);
  localparam int SEL_W     = clog2_min1(K);
  localparam int IDX_W     = idx_w(N, K);

  ctrl_state_t                state;
  logic [CNT_W-1:0]           cnt;
  logic                       load_we;
  logic                       feed_nxt;
  logic [CNT_W-1:0]           nxt_t;
  logic [N-1:0][SEL_W-1:0]    a_sel;
  logic [N-1:0][SEL_W-1:0]    b_sel;
  logic [N-1:0]               a_vld_nxt;
  logic [N-1:0]               b_vld_nxt;
  single_float [N-1:0]        a_rd;
  single_float [N-1:0]        b_rd;
  int                         k;

  assign load_we = bus.ld_en && (state == IDLE);

  sys_arr_operand_buf #(.R(N), .C(K), .IDX_W(IDX_W), .COL_READ(1'b0)) u_buf_a (
    .CLK(CLK), .RST(RST), .we(load_we && bus.ld_sel == MAT_A),
    .wr_row(bus.ld_row), .wr_col(bus.ld_col), .wr_data(bus.ld_data),
    .rd_sel(a_sel), .rd_data(a_rd)
  );

  sys_arr_operand_buf #(.R(K), .C(N), .IDX_W(IDX_W), .COL_READ(1'b1)) u_buf_b (
    .CLK(CLK), .RST(RST), .we(load_we && bus.ld_sel == MAT_B),
    .wr_row(bus.ld_row), .wr_col(bus.ld_col), .wr_data(bus.ld_data),
    .rd_sel(b_sel), .rd_data(b_rd)
  );

  // Edge outputs are registered, so the skew is computed for the feed step of the next cycle.
  always_comb begin
    feed_nxt = 1'b0;
    nxt_t    = '0;
    k        = 0;
    if (state == CLEAR) begin
      feed_nxt = 1'b1;
    end else if (state == FEED && cnt != CNT_W'(FEED_LEN - 1)) begin
      feed_nxt = 1'b1;
      nxt_t    = cnt + 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      k            = int'(nxt_t) - i;
      a_vld_nxt[i] = feed_nxt && (k >= 0) && (k < K);
      b_vld_nxt[i] = a_vld_nxt[i];
      a_sel[i]     = a_vld_nxt[i] ? SEL_W'(k) : '0;
      b_sel[i]     = a_sel[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.pe_clear    <= 1'b0;
      bus.error       <= 1'b0;
      bus.cycle_count <= '0;
      bus.a_out       <= '0;
      bus.a_valid     <= '0;
      bus.b_out       <= '0;
      bus.b_valid     <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.pe_clear <= 1'b0;
      bus.a_valid  <= a_vld_nxt;
      bus.b_valid  <= b_vld_nxt;
      for (int i = 0; i < N; i++) begin
        bus.a_out[i] <= a_vld_nxt[i] ? a_rd[i] : '0;
        bus.b_out[i] <= b_vld_nxt[i] ? b_rd[i] : '0;
      end
      if (state == CLEAR || state == FEED || state == DRAIN) begin
        bus.error       <= bus.error | (|bus.pe_error);
        bus.cycle_count <= bus.cycle_count + 32'd1;
      end
      case (state)
        IDLE: if (bus.start) begin
          state           <= CLEAR;
          bus.pe_clear    <= 1'b1;
          bus.busy        <= 1'b1;
          bus.error       <= 1'b0;
          bus.cycle_count <= 32'd1;
        end
        CLEAR: begin
          state <= FEED;
          cnt   <= '0;
        end
        FEED: if (cnt == CNT_W'(FEED_LEN - 1)) begin
          state <= DRAIN;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DRAIN: if (cnt == CNT_W'(DRAIN_CYC - 1)) begin
          state    <= DONE;
          bus.done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Directed bench for sys_array_ctrl with N=K=2, PE_LAT=4 (run length 11 cycles).
module tb_sys_array_ctrl;
  import dsp_sys_arr_pkg::*;

  localparam int IW = idx_w(2, 2);

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   run_cyc;
  int   clr_cnt;
  logic seen_done;

  sys_array_ctrl_if #(.N(2), .K(2)) bus ();

  sys_array_ctrl #(.N(2), .K(2), .PE_LAT(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input mat_sel_t sel, input int row, input int col, input logic [31:0] data);
    bus.ld_en   = 1'b1;
    bus.ld_sel  = sel;
    bus.ld_row  = IW'(row);
    bus.ld_col  = IW'(col);
    bus.ld_data = data;
    tick();
    bus.ld_en   = 1'b0;
  endtask

  task automatic load_ab();
    load(MAT_A, 0, 0, 32'h3F800000);
    load(MAT_A, 0, 1, 32'h40000000);
    load(MAT_A, 1, 0, 32'h40400000);
    load(MAT_A, 1, 1, 32'h40800000);
    load(MAT_B, 0, 0, 32'h40A00000);
    load(MAT_B, 0, 1, 32'h40C00000);
    load(MAT_B, 1, 0, 32'h40E00000);
    load(MAT_B, 1, 1, 32'h41000000);
  endtask

  // Starts a run; returns in the CLEAR cycle, which is run cycle 1.
  task automatic start_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_cyc   = 1;
    clr_cnt   = int'(bus.pe_clear);
  endtask

  task automatic step();
    tick();
    run_cyc++;
    clr_cnt += int'(bus.pe_clear);
  endtask

  task automatic finish_run();
    while (!bus.done && run_cyc < 40) step();
    chk("done_seen", 32'(bus.done), 32'd1);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.ld_en    = 1'b0;
    bus.ld_sel   = MAT_A;
    bus.ld_row   = '0;
    bus.ld_col   = '0;
    bus.ld_data  = '0;
    bus.pe_error = '0;
    tick();
    tick();
    RST = 1'b0;

    chk("rst_busy",     32'(bus.busy),        32'd0);
    chk("rst_done",     32'(bus.done),        32'd0);
    chk("rst_error",    32'(bus.error),       32'd0);
    chk("rst_clear",    32'(bus.pe_clear),    32'd0);
    chk("rst_cycles",   bus.cycle_count,      32'd0);
    chk("rst_a_valid",  32'(bus.a_valid),     32'd0);
    chk("rst_b_out0",   bus.b_out[0],         32'd0);

    // Run 1: skewed feed of A=[[1,2],[3,4]], B=[[5,6],[7,8]] and run timing
    load_ab();
    start_run();
    chk("clr_pulse",    32'(bus.pe_clear),    32'd1);
    chk("clr_busy",     32'(bus.busy),        32'd1);
    chk("clr_cycles",   bus.cycle_count,      32'd1);
    chk("clr_a_valid",  32'(bus.a_valid),     32'd0);
    step();
    chk("t0_a0",        bus.a_out[0],         32'h3F800000);
    chk("t0_a1",        bus.a_out[1],         32'h00000000);
    chk("t0_a_valid",   32'(bus.a_valid),     32'd1);
    chk("t0_b0",        bus.b_out[0],         32'h40A00000);
    chk("t0_b_valid",   32'(bus.b_valid),     32'd1);
    chk("t0_clear_low", 32'(bus.pe_clear),    32'd0);
    step();
    chk("t1_a0",        bus.a_out[0],         32'h40000000);
    chk("t1_a1",        bus.a_out[1],         32'h40400000);
    chk("t1_b0",        bus.b_out[0],         32'h40E00000);
    chk("t1_b1",        bus.b_out[1],         32'h40C00000);
    chk("t1_a_valid",   32'(bus.a_valid),     32'd3);
    chk("t1_b_valid",   32'(bus.b_valid),     32'd3);
    step();
    chk("t2_a0",        bus.a_out[0],         32'h00000000);
    chk("t2_a1",        bus.a_out[1],         32'h40800000);
    chk("t2_b1",        bus.b_out[1],         32'h41000000);
    chk("t2_a_valid",   32'(bus.a_valid),     32'd2);
    chk("t2_b_valid",   32'(bus.b_valid),     32'd2);
    step();
    chk("drain_a_valid", 32'(bus.a_valid),    32'd0);
    chk("drain_b_out1", bus.b_out[1],         32'd0);
    finish_run();
    chk("run_len",      32'(run_cyc),         32'd11);
    chk("clear_cycles", 32'(clr_cnt),         32'd1);
    chk("done_cycles",  bus.cycle_count,      32'd11);
    chk("done_busy",    32'(bus.busy),        32'd1);
    tick();
    chk("idle_busy",    32'(bus.busy),        32'd0);
    chk("idle_done",    32'(bus.done),        32'd0);
    chk("idle_cycles",  bus.cycle_count,      32'd11);

    // Run 2: one-cycle PE error in DRAIN is sticky through DONE and IDLE
    start_run();
    repeat (5) step();
    bus.pe_error = 4'b1000;
    step();
    bus.pe_error = '0;
    chk("err_set",      32'(bus.error),       32'd1);
    finish_run();
    chk("err_at_done",  32'(bus.error),       32'd1);
    tick();
    chk("err_in_idle",  32'(bus.error),       32'd1);

    // Run 3: clean run clears the flag on entry to CLEAR
    start_run();
    chk("err_clr",      32'(bus.error),       32'd0);
    finish_run();
    chk("err_clean_done", 32'(bus.error),     32'd0);
    tick();

    // Reset in FEED t1 aborts, clears outputs and operand buffers
    start_run();
    step();
    step();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_busy",   32'(bus.busy),        32'd0);
    chk("abort_a_valid", 32'(bus.a_valid),    32'd0);
    chk("abort_b_valid", 32'(bus.b_valid),    32'd0);
    chk("abort_a0",     bus.a_out[0],         32'd0);
    chk("abort_cycles", bus.cycle_count,      32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) seen_done = 1'b1;
      tick();
    end
    chk("abort_no_done", 32'(seen_done),      32'd0);
    start_run();
    step();
    chk("zero_a0",      bus.a_out[0],         32'd0);
    chk("zero_b0",      bus.b_out[0],         32'd0);
    chk("zero_valid",   32'(bus.a_valid),     32'd1);
    finish_run();
    tick();

    // start and load while busy are both ignored
    load_ab();
    start_run();
    repeat (5) step();
    bus.start   = 1'b1;
    bus.ld_en   = 1'b1;
    bus.ld_sel  = MAT_A;
    bus.ld_row  = IW'(0);
    bus.ld_col  = IW'(0);
    bus.ld_data = 32'h41100000;
    step();
    bus.start   = 1'b0;
    bus.ld_en   = 1'b0;
    finish_run();
    chk("busy_run_len", 32'(run_cyc),         32'd11);
    tick();
    tick();
    chk("no_restart",   32'(bus.busy),        32'd0);
    start_run();
    step();
    chk("busy_ld_ign",  bus.a_out[0],         32'h3F800000);
    finish_run();
    tick();

    // Out-of-range writes are dropped
    load(MAT_A, 2, 0, 32'h41100000);
    load(MAT_B, 0, 2, 32'h41100000);
    start_run();
    step();
    chk("oor_t0_a0",    bus.a_out[0],         32'h3F800000);
    chk("oor_t0_b0",    bus.b_out[0],         32'h40A00000);
    step();
    chk("oor_t1_a1",    bus.a_out[1],         32'h40400000);
    chk("oor_t1_b0",    bus.b_out[0],         32'h40E00000);
    step();
    chk("oor_t2_a1",    bus.a_out[1],         32'h40800000);
    chk("oor_t2_b1",    bus.b_out[1],         32'h41000000);
    finish_run();
    tick();

    // start with a simultaneous load: the run feeds the new value
    bus.start   = 1'b1;
    bus.ld_en   = 1'b1;
    bus.ld_sel  = MAT_A;
    bus.ld_row  = IW'(1);
    bus.ld_col  = IW'(1);
    bus.ld_data = 32'h41100000;
    tick();
    bus.start   = 1'b0;
    bus.ld_en   = 1'b0;
    run_cyc     = 1;
    chk("both_busy",    32'(bus.busy),        32'd1);
    step();
    step();
    step();
    chk("both_t2_a1",   bus.a_out[1],         32'h41100000);
    finish_run();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
